// File: rtl/apb_sram_slave.sv
// APB3/APB4 slave fronting a single-port word-addressed SRAM, with optional wait
// states, address/protection error checking and a saturating error counter.
module apb_sram_slave #(
  parameter int ADDR_WD  = 32,
  parameter int DATA_WD  = 32,
  parameter int STRB_WD  = DATA_WD / 8,
  parameter int PROT_WD  = 3,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 0,
  parameter int PROT_CHK = 1
) (
  input  logic               b_pclk,
  input  logic               b_prst_n,
  input  logic               b_psel,
  input  logic               b_penable,
  input  logic               b_pwrite,
  input  logic [ADDR_WD-1:0] b_paddr,
  input  logic [DATA_WD-1:0] b_pwdata,
  input  logic [PROT_WD-1:0] b_pprot,
  input  logic [STRB_WD-1:0] b_pstrb,
  output logic [DATA_WD-1:0] b_prdata,
  output logic               b_pready,
  output logic               b_pslverr,
  output logic [7:0]         b_err_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]         state;
  logic [3:0]         wait_cnt;
  logic               err_q;
  logic [AW-1:0]      idx_q;
  logic [DATA_WD-1:0] mem [DEPTH];

  logic [AW-1:0]      idx;
  logic [ADDR_WD-1:0] hi_bits;
  logic               addr_err;
  logic               prot_err;
  logic               acc_err;
  logic               setup;
  logic               complete;
  logic               do_write;
  logic               unused_prot;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [DATA_WD-1:0] merge_bytes(
    input logic [DATA_WD-1:0] old_w,
    input logic [DATA_WD-1:0] new_w,
    input logic [STRB_WD-1:0] strb
  );
    logic [DATA_WD-1:0] w;
    w = old_w;
    for (int i = 0; i < STRB_WD; i++) begin
      if (strb[i]) w[8*i +: 8] = new_w[8*i +: 8];
    end
    return w;
  endfunction

  // Address bits above the word index must be zero; only pprot[1] is checked.
  assign idx         = b_paddr[AW+1:2];
  assign hi_bits     = b_paddr >> (AW + 2);
  assign addr_err    = (32'(idx) >= DEPTH) || (hi_bits != '0) || (b_paddr[1:0] != 2'b00);
  assign prot_err    = (PROT_CHK != 0) && b_pprot[1];
  assign acc_err     = addr_err || prot_err;
  assign unused_prot = ^b_pprot;

  assign setup     = (state == IDLE) && b_psel && !b_penable;
  assign b_pready  = (state == ACCESS) && (wait_cnt == 4'd0);
  assign b_pslverr = b_pready && err_q;
  assign complete  = (state == ACCESS) && b_psel && b_penable && b_pready;
  assign do_write  = complete && b_pwrite && !err_q;

  always_ff @(posedge b_pclk or negedge b_prst_n) begin
    if (!b_prst_n) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      b_prdata  <= '0;
      b_err_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            state    <= ACCESS;
            wait_cnt <= 4'(WAIT_CYC);
            err_q    <= acc_err;
            idx_q    <= idx;
            b_prdata <= (!acc_err && !b_pwrite) ? mem[idx] : '0;
          end
        end
        ACCESS: begin
          if (!b_psel) begin
            state <= IDLE;
          end else if (b_pready) begin
            if (b_penable) begin
              state <= IDLE;
              if (err_q) b_err_cnt <= sat_inc(b_err_cnt);
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset; a reset forces IDLE so no write can fire.
  always_ff @(posedge b_pclk) begin
    if (do_write) mem[idx_q] <= merge_bytes(mem[idx_q], b_pwdata, b_pstrb);
  end

endmodule

// File: tb/tb_apb_sram_slave.sv
// Scoreboard bench for apb_sram_slave: three instances with 0, 3 and 2 wait states
// share one APB bus and are selected by their own b_psel.
module tb_apb_sram_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [2:0]  pprot = '0;
  logic [3:0]  pstrb = '0;
  logic        psel    [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];
  logic [7:0]  err_cnt [3];

  int waits_of [3] = '{0, 3, 2};

  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] ref_mem [3][256];
  int          exp_cnt [3];
  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 clk = ~clk;

  apb_sram_slave #(.WAIT_CYC(0)) u_dut0 (
    .b_pclk(clk), .b_prst_n(rst_n), .b_psel(psel[0]), .b_penable(penable),
    .b_pwrite(pwrite), .b_paddr(paddr), .b_pwdata(pwdata), .b_pprot(pprot),
    .b_pstrb(pstrb), .b_prdata(prdata[0]), .b_pready(pready[0]),
    .b_pslverr(pslverr[0]), .b_err_cnt(err_cnt[0])
  );

  apb_sram_slave #(.WAIT_CYC(3)) u_dut3 (
    .b_pclk(clk), .b_prst_n(rst_n), .b_psel(psel[1]), .b_penable(penable),
    .b_pwrite(pwrite), .b_paddr(paddr), .b_pwdata(pwdata), .b_pprot(pprot),
    .b_pstrb(pstrb), .b_prdata(prdata[1]), .b_pready(pready[1]),
    .b_pslverr(pslverr[1]), .b_err_cnt(err_cnt[1])
  );

  apb_sram_slave #(.WAIT_CYC(2)) u_dut2 (
    .b_pclk(clk), .b_prst_n(rst_n), .b_psel(psel[2]), .b_penable(penable),
    .b_pwrite(pwrite), .b_paddr(paddr), .b_pwdata(pwdata), .b_pprot(pprot),
    .b_pstrb(pstrb), .b_prdata(prdata[2]), .b_pready(pready[2]),
    .b_pslverr(pslverr[2]), .b_err_cnt(err_cnt[2])
  );

  // One complete transfer on instance d; expectations come from the bench's own model.
  task automatic apb_xfer(input int d, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [2:0] prot, input string tag);
    exp_t e;
    exp_t got;
    int   waits;
    int   idx;
    bit   err;
    idx = int'(addr[9:2]);
    err = (addr[31:10] != 22'd0) || (addr[1:0] != 2'b00) || prot[1];
    e.slverr = err;
    e.rdata  = (err || wr) ? 32'h0 : ref_mem[d][idx];
    if (wr && !err) begin
      for (int i = 0; i < 4; i++)
        if (strb[i]) ref_mem[d][idx][8*i +: 8] = wdata[8*i +: 8];
    end
    if (err && exp_cnt[d] < 255) exp_cnt[d]++;
    sb.push_back(e);

    tests_run++;
    if (pready[d] !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s idle_pready: got %b want 0", tag, pready[d]);
    end
    psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = wdata; pstrb = strb; pprot = prot;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    while (pready[d] !== 1'b1 && waits < 40) begin
      @(posedge clk); #1;
      waits++;
    end
    tests_run++;
    if (waits != waits_of[d]) begin
      tests_failed++;
      $display("FAIL %s wait_states: got %0d want %0d", tag, waits, waits_of[d]);
    end
    got = sb.pop_front();
    tests_run++;
    if (pslverr[d] !== got.slverr) begin
      tests_failed++;
      $display("FAIL %s pslverr: got %b want %b", tag, pslverr[d], got.slverr);
    end
    tests_run++;
    if (prdata[d] !== got.rdata) begin
      tests_failed++;
      $display("FAIL %s prdata: got %h want %h", tag, prdata[d], got.rdata);
    end
    @(posedge clk); #1;
    psel[d] = 1'b0; penable = 1'b0; pwrite = 1'b0;
    tests_run++;
    if (err_cnt[d] !== 8'(exp_cnt[d])) begin
      tests_failed++;
      $display("FAIL %s err_cnt: got %0d want %0d", tag, err_cnt[d], exp_cnt[d]);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) psel[d] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      tests_run++;
      if (prdata[d] !== 32'h0 || pready[d] !== 1'b0 || pslverr[d] !== 1'b0 || err_cnt[d] !== 8'd0) begin
        tests_failed++;
        $display("FAIL reset_state dut%0d: got rdata=%h rdy=%b err=%b cnt=%0d want all 0",
                 d, prdata[d], pready[d], pslverr[d], err_cnt[d]);
      end
      exp_cnt[d] = 0;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    apb_xfer(0, 1'b1, 32'h10, 32'hA5A5_1234, 4'hF, 3'b000, "basic_wr");
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, "basic_rd");
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (prdata[0] !== 32'hA5A5_1234) begin
      tests_failed++;
      $display("FAIL rdata_hold: got %h want a5a51234", prdata[0]);
    end
  endtask

  task automatic test_strobe;
    apb_xfer(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h2, 3'b000, "strb_wr");
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, "strb_rd");
    tests_run++;
    if (ref_mem[0][4] !== 32'hA5A5_FF34) begin
      tests_failed++;
      $display("FAIL strb_model: got %h want a5a5ff34", ref_mem[0][4]);
    end
    apb_xfer(0, 1'b1, 32'h10, 32'h0000_0000, 4'h0, 3'b000, "strb0_wr");
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, "strb0_rd");
  endtask

  task automatic test_back_to_back;
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 32'h100 + 32'(4 * i);
      apb_xfer(0, 1'b1, a, $urandom, 4'(1 + $urandom_range(0, 14)), 3'b000, "b2b_wr");
    end
    for (int i = 0; i < 4; i++) begin
      a = 32'h100 + 32'(4 * i);
      apb_xfer(0, 1'b0, a, 32'h0, 4'h0, 3'b000, "b2b_rd");
    end
    apb_xfer(0, 1'b1, 32'h3FC, 32'h1357_9BDF, 4'hF, 3'b000, "top_wr");
    apb_xfer(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 3'b000, "top_rd");
  endtask

  task automatic test_wait_states;
    apb_xfer(1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 3'b000, "wait3_wr");
    apb_xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, 3'b000, "wait3_rd");
    apb_xfer(2, 1'b1, 32'h20, 32'h1111_1111, 4'hF, 3'b000, "wait2_wr");
    apb_xfer(2, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000, "wait2_rd");
  endtask

  task automatic test_errors;
    apb_xfer(0, 1'b0, 32'h400, 32'h0, 4'h0, 3'b000, "err_range");
    apb_xfer(0, 1'b1, 32'h11, 32'h5555_5555, 4'hF, 3'b000, "err_align");
    apb_xfer(0, 1'b1, 32'h10, 32'h6666_6666, 4'hF, 3'b010, "err_prot");
    tests_run++;
    if (err_cnt[0] !== 8'd3) begin
      tests_failed++;
      $display("FAIL err_cnt_three: got %0d want 3", err_cnt[0]);
    end
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, "err_unchanged");
    apb_xfer(0, 1'b1, 32'h0001_0010, 32'h7777_7777, 4'hF, 3'b000, "err_hibits");
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b001, "prot_ok_rd");
  endtask

  // Drop psel after one access cycle on the 3-wait-state instance.
  task automatic abort_xfer(input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr;
    pwdata = wdata; pstrb = 4'hF; pprot = 3'b000;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel[1] = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (pready[1] !== 1'b0 || err_cnt[1] !== 8'(exp_cnt[1])) begin
      tests_failed++;
      $display("FAIL %s: got rdy=%b cnt=%0d want rdy=0 cnt=%0d", tag, pready[1], err_cnt[1], exp_cnt[1]);
    end
  endtask

  task automatic test_abort;
    abort_xfer(32'h40, 32'h0BAD_0BAD, "abort_ok");
    abort_xfer(32'h41, 32'h0BAD_0BAD, "abort_err");
    apb_xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, 3'b000, "abort_rd");
  endtask

  task automatic test_reset_mid;
    apb_xfer(2, 1'b0, 32'h3, 32'h0, 4'h0, 3'b000, "mid_pre_err");
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20;
    pwdata = 32'h2222_2222; pstrb = 4'hF; pprot = 3'b000;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (prdata[2] !== 32'h0 || pready[2] !== 1'b0 || pslverr[2] !== 1'b0 || err_cnt[2] !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: got rdata=%h rdy=%b err=%b cnt=%0d want all 0",
               prdata[2], pready[2], pslverr[2], err_cnt[2]);
    end
    psel[2] = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) exp_cnt[d] = 0;
    @(posedge clk); #1;
    apb_xfer(2, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000, "mid_after_rd");
    apb_xfer(2, 1'b1, 32'h20, 32'h3333_3333, 4'hF, 3'b000, "mid_after_wr");
    apb_xfer(2, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000, "mid_after_rd2");
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 260; i++)
      apb_xfer(0, 1'b0, 32'h3, 32'h0, 4'h0, 3'b000, "sat");
    tests_run++;
    if (err_cnt[0] !== 8'd255) begin
      tests_failed++;
      $display("FAIL err_cnt_sat: got %0d want 255", err_cnt[0]);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) psel[d] = 1'b0;
    test_reset();
    test_basic();
    test_strobe();
    test_back_to_back();
    test_wait_states();
    test_errors();
    test_abort();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
